// File: rtl/fifo4_16bit_pkg.sv
// Shared constants and types for the 4-entry, 16-bit FIFO.
package fifo4_16bit_pkg;

    localparam int FIFO4_DEPTH = 4;
    localparam int PTR_W       = 2;
    localparam int CNT_W       = 3;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/fifo4_16bit_if.sv
// Producer/consumer handshake bundle of the FIFO.
interface fifo4_16bit_if import fifo4_16bit_pkg::*; ();

    word_t             inData;
    logic              inValid;
    logic              inReady;
    word_t             outData;
    logic              outValid;
    logic              outReady;
    logic [CNT_W-1:0]  count;

    // FIFO side
    modport slave (
        input  inData, inValid, outReady,
        output inReady, outData, outValid, count
    );

    // Producer/consumer side
    modport master (
        output inData, inValid, outReady,
        input  inReady, outData, outValid, count
    );

endinterface

// File: rtl/Mux4way16bit.sv
// Four-way 16-bit selector used for the FIFO read path.
module Mux4way16bit import fifo4_16bit_pkg::*; (
    output word_t             out,
    input  logic [PTR_W-1:0]  select,
    input  word_t             inA,
    input  word_t             inB,
    input  word_t             inC,
    input  word_t             inD
);

    // Pure combinational selection of one of four words
    always_comb begin
        out = inA;
        case (select)
            2'd0:    out = inA;
            2'd1:    out = inB;
            2'd2:    out = inC;
            2'd3:    out = inD;
            default: out = inA;
        endcase
    end

endmodule

// File: rtl/fifo4_16bit.sv
// 4-entry, 16-bit synchronous FIFO with valid/ready handshake on both sides.
// Flags are decoded from the registered count only, so there is no
// combinational path from outReady to inReady and no fall-through.
module fifo4_16bit import fifo4_16bit_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = FIFO4_DEPTH
) (
    input  logic          clock,
    input  logic          reset_n,
    fifo4_16bit_if.slave  bus
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             wr_en;
    logic             rd_en;

    assign bus.inReady  = (count_q != CNT_W'(FIFO4_DEPTH));
    assign bus.outValid = (count_q != '0);
    assign bus.count    = count_q;

    assign wr_en = bus.inValid  && bus.inReady;
    assign rd_en = bus.outValid && bus.outReady;

    // One-hot entry write enable decoded from the write pointer
    always_comb begin
        wr_sel         = '0;
        wr_sel[wr_ptr] = wr_en;
    end

    // Storage: an entry only loads on its own write enable, so input X
    // outside a write event never reaches stored state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) mem[i] <= bus.inData;
            end
        end
    end

    // Pointers wrap naturally at 2 bits; count tracks net occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    Mux4way16bit u_read_mux (
        .out    (bus.outData),
        .select (rd_ptr),
        .inA    (mem[0]),
        .inB    (mem[1]),
        .inC    (mem[2]),
        .inD    (mem[3])
    );

endmodule

// File: doc/fifo4_16bit.md
FIFO4_16BIT -- requirements
Module: fifo4_16bit

Interface
REQ-001 Parameter WIDTH, default 16: data word width; the block SHALL be verified at 16 only.
REQ-002 Parameter DEPTH, default 4: entry count; fixed at 4 so the read select is exactly 2 bits.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 inData  input  16  write word.
REQ-006 inValid  input  1  producer offers inData this cycle.
REQ-007 inReady  output  1  FIFO accepts a word this cycle.
REQ-008 outData  output  16  head-of-queue word.
REQ-009 outValid  output  1  outData holds a valid head word.
REQ-010 outReady  input  1  consumer takes the head word this cycle.
REQ-011 count  output  3  number of stored words, range 0..4.

Function
REQ-012 Write event = inValid && inReady at a rising clock edge; the word SHALL be stored at mem[wrPtr], then wrPtr increments.
REQ-013 Read event = outValid && outReady at a rising clock edge; rdPtr SHALL increment.
REQ-014 inReady SHALL equal (count != 4), decoded from registered count only, with no combinational path from outReady.
REQ-015 outValid SHALL equal (count != 0), decoded from registered count only.
REQ-016 outData SHALL equal mem[rdPtr] combinationally, selected through a 4-way 16-bit mux with select = rdPtr.
REQ-017 Write-to-read latency SHALL be 1 cycle: a word written into an empty FIFO appears with outValid high after that edge.
REQ-018 There is no fall-through bypass: while empty, outValid stays low in the same cycle as the write.
REQ-019 rdPtr and wrPtr are 2-bit counters and SHALL wrap from 3 to 0 without any extra state.
REQ-020 count SHALL change as follows: +1 on write only, -1 on read only, unchanged on simultaneous write and read, unchanged when neither occurs.
REQ-021 Full (count = 4):
  - inReady is low, so an offered inValid is ignored and no data is overwritten.
  - A read still proceeds, and inReady rises the following cycle.
REQ-022 Empty (count = 0):
  - outValid is low, so outReady is ignored and rdPtr holds.
REQ-023 Simultaneous write and read at 1 <= count <= 3 SHALL both take effect in the same edge.
REQ-024 Ordering SHALL be strict FIFO: words leave in acceptance order, with no loss or duplication.
REQ-025 inData and inValid SHALL be don't-care while inReady is low. Input X SHALL NOT corrupt stored state unless a write event occurs.

Reset
REQ-026 reset_n low SHALL immediately and asynchronously force rdPtr = 0, wrPtr = 0, count = 0, and all four mem entries = 16'h0000.
REQ-027 During and after reset: inReady = 1, outValid = 0, outData = 16'h0000, count = 0.
REQ-028 Reset asserted mid-operation, full or partially full, SHALL discard all stored words. No event is performed on the edge coinciding with reset release.

Structure
REQ-029 Shared package SHALL hold FIFO4_DEPTH = 4, the pointer width 2, the count width 3, and a 16-bit word typedef.
REQ-030 The read-select path SHALL instantiate the existing Mux4way16bit sub-module (ports out, select, inA..inD mapped to mem[0..3]). No other sub-module is required.
REQ-031 Storage SHALL be four 16-bit registers with per-entry write enables decoded from wrPtr. There SHALL be no latches.

Verification
REQ-032 Reset check: assert reset_n = 0 mid-cycle -> outputs switch without a clock edge to inReady = 1, outValid = 0, count = 0, outData = 0000.
REQ-033 Fill then drain:
  - Write 1234, 9876, AAAA, 5555 with outReady = 0 -> count = 4, inReady = 0.
  - Then hold outReady = 1 -> outData sequence 1234, 9876, AAAA, 5555, then outValid = 0 and count = 0.
REQ-034 Overflow: at full, drive inValid = 1 with inData = FFFF -> no change, count stays 4; FFFF never appears at the output.
REQ-035 Wrap-around: run 10 consecutive writes and reads with count held at 1..2 -> pointers wrap and all 10 words emerge in order.
REQ-036 Concurrent operation: at count = 2, perform a simultaneous write of 0F0F and a read -> count stays 2; head advances; 0F0F emerges third.
REQ-037 Reset mid-stream: at count = 3, pulse reset_n low -> count = 0, outValid = 0. The next written word (BEEF) is the first word read out.
